map_scroller: RTL and testbench
===============================

MAP_SCROLLER -- requirements
Module: map_scroller

Interface
REQ-001 Parameter LANES, default 4, meaning lanes per map row; legal range 2..8.
REQ-002 Parameter DEPTH, default 16, meaning rows in map; legal range 4..32.
REQ-003 Parameter MIN_GAP, default 1, meaning forced obstacle-free rows inserted after each non-empty obstacle row; legal range 0..7.
REQ-004 Parameter SEED, default 16'hACE1, meaning LFSR reset value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 move_map  input  1  shift map one row down on this edge.
REQ-008 sel_obstacle  input  1  request an obstacle row on the next insert.
REQ-009 sel_objective  input  1  request an objective on the next insert.
REQ-010 density  input  2  obstacle density mode.
REQ-011 player_lane  input  3  player lane, compared against row 0.
REQ-012 collect  input  1  clear the objective at row 0, player_lane.
REQ-013 map_obstacles_flat  output  LANES*DEPTH  obstacle bitmap; row r at [r*LANES +: LANES]; row 0 is bottom (player row).
REQ-014 map_objectives_flat  output  LANES*DEPTH  objective bitmap, same layout.
REQ-015 obstacle_generated  output  1  one-cycle pulse when an inserted obstacle row is non-zero.
REQ-016 objective_generated  output  1  one-cycle pulse when an objective is inserted.
REQ-017 hit_obstacle  output  1  obstacle bit at row 0, player_lane.
REQ-018 hit_objective  output  1  objective bit at row 0, player_lane.
REQ-019 spawn_count  output  8  saturating count of inserted objectives.

Function
REQ-020 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every clock, independent of move_map.
REQ-021 On a move_map edge: row r SHALL take row r+1 for r < DEPTH-1; row 0 is discarded; the new row is written to row DEPTH-1, all on the same edge.
REQ-022 Candidate obstacle row SHALL be derived by density: 0 = one-hot at lane LFSR[2:0] mod LANES; 1 = LFSR[LANES-1:0] AND LFSR[LANES+7:8]; 2 = LFSR[LANES-1:0]; 3 = all ones except lane LFSR[2:0] mod LANES.
REQ-023 If the candidate is all ones, bit (LFSR[2:0] mod LANES) SHALL be cleared; an inserted obstacle row is never full.
REQ-024 Inserted obstacle row SHALL be zero when sel_obstacle=0 or gap counter is non-zero; otherwise it is the candidate.
REQ-025 Gap counter SHALL load MIN_GAP on an edge that inserts a non-zero obstacle row, decrement (floor 0) on every other move_map edge, and hold otherwise.
REQ-026 With sel_objective=1, the objective SHALL be one-hot at lane LFSR[15:13] mod LANES; if that lane is blocked in the inserted obstacle row, it moves to the lowest-index free lane.
REQ-027 obstacle_generated and objective_generated SHALL be high exactly one cycle, in the cycle following the inserting edge, and low otherwise.
REQ-028 spawn_count SHALL increment per inserted objective and saturate at 255.
REQ-029 hit_obstacle and hit_objective SHALL be combinational from registered row 0; both SHALL be 0 when player_lane >= LANES.
REQ-030 collect=1 without move_map SHALL clear the row-0 objective bit at player_lane; collect is ignored when player_lane >= LANES.
REQ-031 collect coincident with move_map SHALL be ignored; the shift takes priority.
REQ-032 With move_map=0, all map bits SHALL hold, except as cleared by collect.

Reset
REQ-033 While reset=0: both maps SHALL be zero, the LFSR SHALL hold SEED, and gap counter, spawn_count, and both pulses SHALL be zero, asynchronously.
REQ-034 Reset asserted mid-operation SHALL discard any pending shift; the first move_map after release operates on an all-zero map.

Verification
REQ-035 Reset, then 16 move_map pulses with sel_obstacle=sel_objective=0 -> both maps remain 0, no pulses, spawn_count=0.
REQ-036 density=3, sel_obstacle=1, MIN_GAP=1, continuous move_map -> inserted rows alternate non-zero/zero; every non-zero row has exactly one 0 bit.
REQ-037 sel_objective=1, 300 inserts -> spawn_count=255; every objective bit is one-hot and never overlaps an obstacle bit in its row.
REQ-038 Load objective at row 0, player_lane=2; pulse collect -> hit_objective goes 1->0 next cycle; the same test with move_map coincident -> the bit shifts out instead, spawn_count unchanged.
REQ-039 player_lane=5 with LANES=4 -> hit_obstacle=hit_objective=0, collect has no effect.
REQ-040 Assert reset mid-stream while move_map=1 -> all outputs 0 immediately; after release, the map sequence repeats the reset-seeded sequence cycle-exact.

Source files
------------

// File: rtl/map_scroller.sv
// map_scroller: scrolling lane map with LFSR-driven obstacle and objective rows
module map_scroller #(
    parameter int          LANES   = 4,
    parameter int          DEPTH   = 16,
    parameter int          MIN_GAP = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   move_map_i,
    input  logic                   sel_obstacle_i,
    input  logic                   sel_objective_i,
    input  logic [1:0]             density_i,
    input  logic [2:0]             player_lane_i,
    input  logic                   collect_i,
    output logic [LANES*DEPTH-1:0] map_obstacles_flat_o,
    output logic [LANES*DEPTH-1:0] map_objectives_flat_o,
    output logic                   obstacle_generated_o,
    output logic                   objective_generated_o,
    output logic                   hit_obstacle_o,
    output logic                   hit_objective_o,
    output logic [7:0]             spawn_count_o
);
    localparam int               W        = LANES * DEPTH;
    localparam logic [15:0]      SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;
    localparam logic [LANES-1:0] ONE      = {{(LANES-1){1'b0}}, 1'b1};

    logic [15:0]      lfsr_q, lfsr_d;
    logic [W-1:0]     obs_q, obs_d, obj_q, obj_d;
    logic [2:0]       gap_q, gap_d;
    logic [7:0]       spawn_q, spawn_d;
    logic             obs_gen_q, obj_gen_q;
    logic [2:0]       obs_lane, obj_pref, obj_low, obj_lane;
    logic [LANES-1:0] obs_oh, cand, cand_nf, ins_obs, ins_obj, free, clr_mask;
    logic [7:0]       free8, row0_obs8, row0_obj8;
    logic             lane_ok;

    // Galois LFSR, taps x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Candidate obstacle row, never allowed to block every lane
    assign obs_lane = 3'(32'(lfsr_q[2:0]) % LANES);
    assign obs_oh   = ONE << obs_lane;
    assign cand     = (density_i == 2'd0) ? obs_oh :
                      (density_i == 2'd1) ? (lfsr_q[LANES-1:0] & lfsr_q[LANES+7:8]) :
                      (density_i == 2'd2) ? lfsr_q[LANES-1:0] : ~obs_oh;
    assign cand_nf  = (&cand) ? (cand & ~obs_oh) : cand;
    assign ins_obs  = (sel_obstacle_i && gap_q == 3'd0) ? cand_nf : '0;

    // Objective lane falls back to the lowest free lane when its preferred lane is blocked
    assign free     = ~ins_obs;
    assign free8    = 8'(free);
    assign obj_pref = 3'(32'(lfsr_q[15:13]) % LANES);

    // Lowest-index lane left open by the inserted obstacle row
    always_comb begin
        obj_low = 3'd0;
        for (int i = LANES - 1; i >= 0; i--) if (free8[i]) obj_low = 3'(i);
    end

    assign obj_lane = free8[obj_pref] ? obj_pref : obj_low;
    assign ins_obj  = sel_objective_i ? (ONE << obj_lane) : '0;

    // Player lane lookups on row 0; lanes past LANES see nothing and collect nothing
    assign lane_ok   = 32'(player_lane_i) < LANES;
    assign clr_mask  = (collect_i && lane_ok) ? (ONE << player_lane_i) : '0;
    assign row0_obs8 = 8'(obs_q[LANES-1:0]);
    assign row0_obj8 = 8'(obj_q[LANES-1:0]);

    // Next-state: shift takes priority over collect; gap and spawn only move on shifts
    always_comb begin
        obs_d   = move_map_i ? {ins_obs, obs_q[W-1:LANES]} : obs_q;
        obj_d   = move_map_i ? {ins_obj, obj_q[W-1:LANES]} : (obj_q & ~{{(W-LANES){1'b0}}, clr_mask});
        gap_d   = !move_map_i ? gap_q : (|ins_obs) ? 3'(MIN_GAP) : (gap_q != 3'd0) ? gap_q - 3'd1 : gap_q;
        spawn_d = (move_map_i && sel_objective_i && spawn_q != 8'hFF) ? spawn_q + 8'd1 : spawn_q;
    end

    // State registers and one-cycle generation pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q    <= SEED_EFF;
            obs_q     <= '0;
            obj_q     <= '0;
            gap_q     <= 3'd0;
            spawn_q   <= 8'd0;
            obs_gen_q <= 1'b0;
            obj_gen_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            obs_q     <= obs_d;
            obj_q     <= obj_d;
            gap_q     <= gap_d;
            spawn_q   <= spawn_d;
            obs_gen_q <= move_map_i && (|ins_obs);
            obj_gen_q <= move_map_i && sel_objective_i;
        end
    end

    assign map_obstacles_flat_o  = obs_q;
    assign map_objectives_flat_o = obj_q;
    assign obstacle_generated_o  = obs_gen_q;
    assign objective_generated_o = obj_gen_q;
    assign spawn_count_o         = spawn_q;
    assign hit_obstacle_o        = lane_ok && row0_obs8[player_lane_i];
    assign hit_objective_o       = lane_ok && row0_obj8[player_lane_i];
endmodule

// File: tb/tb_map_scroller.sv
// tb_map_scroller: directed + random bench against a row-array reference model
module tb_map_scroller;
    localparam int L = 4;
    localparam int D = 16;
    localparam int G = 1;
    localparam int FULL = (1 << L) - 1;

    logic clk = 0, rst_n = 1, mv = 0, so = 0, sj = 0, col = 0;
    logic [1:0] dens = 0;
    logic [2:0] pl = 0;
    logic [L*D-1:0] map_obs, map_obj;
    logic obs_gen, obj_gen, hit_obs, hit_obj;
    logic [7:0] spawn_cnt;

    always #5 clk = ~clk;

    map_scroller #(.LANES(L), .DEPTH(D), .MIN_GAP(G), .SEED(16'hACE1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .move_map_i(mv), .sel_obstacle_i(so),
        .sel_objective_i(sj), .density_i(dens), .player_lane_i(pl), .collect_i(col),
        .map_obstacles_flat_o(map_obs), .map_objectives_flat_o(map_obj),
        .obstacle_generated_o(obs_gen), .objective_generated_o(obj_gen),
        .hit_obstacle_o(hit_obs), .hit_objective_o(hit_obj), .spawn_count_o(spawn_cnt)
    );

    int vectors = 0, miscompares = 0;
    int lf, gap, spawn;
    int mobs[D], mobj[D];
    bit pob, pobj;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int s);
        int ex[4] = '{16, 14, 13, 11};
        int m = 0;
        foreach (ex[k]) m |= 1 << (ex[k] - 1);
        return (s & 1) ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    function automatic logic [63:0] flat(input bit objectives);
        logic [63:0] f = '0;
        for (int r = 0; r < D; r++) f |= 64'(objectives ? mobj[r] : mobs[r]) << (r * L);
        return f;
    endfunction

    task automatic model_reset();
        lf = 16'hACE1; gap = 0; spawn = 0; pob = 0; pobj = 0;
        for (int r = 0; r < D; r++) begin mobs[r] = 0; mobj[r] = 0; end
    endtask

    task automatic model_edge();
        int lane, cand, ins, obj, ol, nxt;
        bit found;
        nxt = lfsr_next(lf);
        if (mv) begin
            lane = (lf & 7) % L;
            case (dens)
                2'd0: cand = 1 << lane;
                2'd1: cand = (lf & FULL) & ((lf >> 8) & FULL);
                2'd2: cand = lf & FULL;
                default: cand = FULL & ~(1 << lane);
            endcase
            if (cand == FULL) cand &= ~(1 << lane);
            ins = (so && gap == 0) ? cand : 0;
            gap = (ins != 0) ? G : (gap > 0 ? gap - 1 : 0);
            obj = 0;
            if (sj) begin
                ol = ((lf >> 13) & 7) % L;
                if ((ins >> ol) & 1) begin
                    found = 0;
                    for (int i = 0; i < L; i++) if (!found && !((ins >> i) & 1)) begin ol = i; found = 1; end
                end
                obj = 1 << ol;
                spawn = (spawn < 255) ? spawn + 1 : 255;
            end
            for (int r = 0; r < D - 1; r++) begin mobs[r] = mobs[r+1]; mobj[r] = mobj[r+1]; end
            mobs[D-1] = ins; mobj[D-1] = obj;
            pob = (ins != 0); pobj = sj;
        end else begin
            pob = 0; pobj = 0;
            if (col && pl < L) mobj[0] &= ~(1 << pl);
        end
        lf = nxt;
    endtask

    task automatic check_all();
        chk("obs_map", map_obs, flat(0));
        chk("obj_map", map_obj, flat(1));
        chk("obs_pulse", obs_gen, pob);
        chk("obj_pulse", obj_gen, pobj);
        chk("hit_obs", hit_obs, (pl < L) ? (mobs[0] >> pl) & 1 : 0);
        chk("hit_obj", hit_obj, (pl < L) ? (mobj[0] >> pl) & 1 : 0);
        chk("spawn", spawn_cnt, spawn);
    endtask

    task automatic step(input bit m, input bit s, input bit j, input int d, input int p, input bit c);
        mv = m; so = s; sj = j; dens = 2'(d); pl = 3'(p); col = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_obs"}, map_obs, 0);
        chk({tag, "_obj"}, map_obj, 0);
        chk({tag, "_pulses"}, {obs_gen, obj_gen, hit_obs, hit_obj}, 0);
        chk({tag, "_spawn"}, spawn_cnt, 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [63:0] rec_obs[24], rec_obj[24];
    bit s_so[24], s_sj[24];
    int s_d[24];
    logic [L-1:0] top_o, top_j;
    int n, sp;

    initial begin
        do_reset();
        // empty inserts keep everything clear
        for (int i = 0; i < 16; i++) step(1, 0, 0, $urandom_range(0, 3), $urandom_range(0, 7), 0);
        check_zero("empty_run");
        // dense rows alternate with forced gaps
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 3, 0, 0);
            top_o = map_obs[(D-1)*L +: L];
            chk("gap_alt", top_o != 0, (i % 2) == 0);
            if ((i % 2) == 0) chk("one_zero", $countones(top_o), L - 1);
        end
        // fully random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
        // objective every insert saturates the counter
        for (int i = 0; i < 300; i++) begin
            step(1, $urandom_range(0, 1), 1, $urandom_range(0, 3), $urandom_range(0, 7), 0);
            top_o = map_obs[(D-1)*L +: L];
            top_j = map_obj[(D-1)*L +: L];
            chk("obj_onehot", $countones(top_j), 1);
            chk("obj_overlap", top_o & top_j, 0);
        end
        chk("spawn_sat", spawn_cnt, 255);
        // collect at lane 2
        do_reset();
        n = 0;
        while (!((mobj[0] >> 2) & 1) && n < 200) begin step(1, $urandom_range(0, 1), 1, $urandom_range(0, 3), 2, 0); n++; end
        chk("find_obj_a", n < 200, 1);
        step(0, 0, 0, 0, 2, 0);
        chk("hit_before_collect", hit_obj, 1);
        step(0, 0, 0, 0, 2, 1);
        chk("hit_after_collect", hit_obj, 0);
        n = 0;
        while (!((mobj[0] >> 2) & 1) && n < 200) begin step(1, $urandom_range(0, 1), 1, $urandom_range(0, 3), 2, 0); n++; end
        chk("find_obj_b", n < 200, 1);
        sp = spawn;
        step(1, 0, 0, 0, 2, 1);
        chk("collect_shift_spawn", spawn_cnt, sp);
        // out-of-range player lane
        step(0, 0, 0, 0, 5, 1);
        chk("lane5_hit_obs", hit_obs, 0);
        chk("lane5_hit_obj", hit_obj, 0);
        // reset mid-stream then replay the reset-seeded sequence
        for (int i = 0; i < 24; i++) begin s_so[i] = 1'($urandom_range(0, 1)); s_sj[i] = 1'($urandom_range(0, 1)); s_d[i] = $urandom_range(0, 3); end
        do_reset();
        for (int i = 0; i < 24; i++) begin step(1, s_so[i], s_sj[i], s_d[i], 0, 0); rec_obs[i] = flat(0); rec_obj[i] = flat(1); end
        do_reset();
        for (int i = 0; i < 12; i++) step(1, s_so[i], s_sj[i], s_d[i], 0, 0);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1, s_so[i], s_sj[i], s_d[i], 0, 0);
            chk("replay_obs", map_obs, rec_obs[i]);
            chk("replay_obj", map_obj, rec_obj[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
